// File: rtl/trdb_pkg.sv
// Shared trace-encoder types: packet formats, sync subformats and the
// packet scheduler's FSM state and queue entry layout.
package trdb_pkg;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_SUPPORT = 2'h3
  } trdb_f_sync_subformat_e;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    DRAIN   = 2'h1,
    SUPPORT = 2'h2,
    HOLD    = 2'h3
  } trdb_sched_state_e;

  typedef struct packed {
    trdb_format_e           format;
    trdb_f_sync_subformat_e subformat;
    logic                   thaddr;
    logic                   cause_mux;
    logic                   tval_mux;
  } trdb_sched_entry_t;

  localparam trdb_sched_entry_t SUPPORT_ENTRY = '{
    format:    F_SYNC,
    subformat: SF_SUPPORT,
    thaddr:    1'b0,
    cause_mux: 1'b0,
    tval_mux:  1'b0
  };

endpackage

// File: rtl/trdb_packet_scheduler_if.sv
// Request bus from the format selector and valid/ready packet bus to the
// emitter; the scheduler sits on the slave modport.
interface trdb_packet_scheduler_if;
  import trdb_pkg::*;

  logic                   req_valid_i;
  trdb_format_e           req_format_i;
  trdb_f_sync_subformat_e req_subformat_i;
  logic                   req_thaddr_i;
  logic                   req_cause_mux_i;
  logic                   req_tval_mux_i;

  logic                   pkt_valid_o;
  logic                   pkt_ready_i;
  trdb_format_e           pkt_format_o;
  trdb_f_sync_subformat_e pkt_subformat_o;
  logic                   pkt_thaddr_o;
  logic                   pkt_cause_mux_o;
  logic                   pkt_tval_mux_o;
  logic                   pkt_sideband_o;

  modport master (
    output req_valid_i, req_format_i, req_subformat_i,
           req_thaddr_i, req_cause_mux_i, req_tval_mux_i,
    output pkt_ready_i,
    input  pkt_valid_o, pkt_format_o, pkt_subformat_o,
           pkt_thaddr_o, pkt_cause_mux_o, pkt_tval_mux_o, pkt_sideband_o
  );

  modport slave (
    input  req_valid_i, req_format_i, req_subformat_i,
           req_thaddr_i, req_cause_mux_i, req_tval_mux_i,
    input  pkt_ready_i,
    output pkt_valid_o, pkt_format_o, pkt_subformat_o,
           pkt_thaddr_o, pkt_cause_mux_o, pkt_tval_mux_o, pkt_sideband_o
  );

endinterface

// File: rtl/trdb_sched_fifo.sv
// First-word-fall-through queue for the packet scheduler; head entry is
// read straight from the storage array, occupancy tracked separately.
module trdb_sched_fifo
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = trdb_sched_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  entry_t                       data_i,
  input  logic                         pop_i,
  output entry_t                       data_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            doPush, doPop;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CntW'(DEPTH)) || doPop);

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Packet scheduler: queues selector requests, injects halted/reset support
// packets and runs the resync timer. TRDB_PACKETS_LOST_EN enables drop reporting.
module trdb_packet_scheduler
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_RESYNC = 16,
  parameter int unsigned RESYNC_W   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  trdb_packet_scheduler_if.slave schedBus,
  input  logic                   halted_i,
  input  logic                   reset_i,
  input  logic                   resync_rst_i,
  input  logic                   resync_cnt_en_i,
  output logic                   max_resync_o,
  output logic                   packets_lost_o
);

  trdb_sched_state_e             state_q, state_d;
  logic                          sb, sb_q, sbRise;
  logic                          sbKind_q, sbKind_d;
  logic [$clog2(DEPTH+1)-1:0]    fifoCount;
  logic                          fifoFull, fifoEmpty;
  logic                          fromQueue, popReq, acceptPush;
  logic                          pktValid, pktSideband;
  trdb_sched_entry_t             reqEntry, pushEntry, headEntry, pktEntry;
  logic [RESYNC_W-1:0]           resyncCnt_q, resyncCnt_d;

  assign reqEntry = '{
    format:    schedBus.req_format_i,
    subformat: schedBus.req_subformat_i,
    thaddr:    schedBus.req_thaddr_i,
    cause_mux: schedBus.req_cause_mux_i,
    tval_mux:  schedBus.req_tval_mux_i
  };

  assign sb         = halted_i | reset_i;
  assign sbRise     = sb & ~sb_q;
  assign fifoEmpty  = (fifoCount == '0);
  assign popReq     = fromQueue && schedBus.pkt_ready_i;
  assign acceptPush = schedBus.req_valid_i && (!fifoFull || popReq);

  trdb_sched_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (trdb_sched_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (acceptPush),
    .data_i  (pushEntry),
    .pop_i   (popReq),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .count_o (fifoCount)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sbKind_q <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sbKind_q <= sbKind_d;
      sb_q     <= sb;
    end
  end

  // Queue fields are forced to zero while empty so a fresh reset shows all-zero outputs.
  always_comb begin
    state_d     = state_q;
    sbKind_d    = sbKind_q;
    fromQueue   = 1'b1;
    pktValid    = !fifoEmpty;
    pktEntry    = fifoEmpty ? '0 : headEntry;
    pktSideband = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sbRise) begin
          sbKind_d = reset_i;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty && !schedBus.req_valid_i) state_d = SUPPORT;
      end
      SUPPORT: begin
        fromQueue   = 1'b0;
        pktValid    = 1'b1;
        pktEntry    = SUPPORT_ENTRY;
        pktSideband = sbKind_q;
        if (schedBus.pkt_ready_i) state_d = HOLD;
      end
      HOLD: begin
        if (!sb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign schedBus.pkt_valid_o     = pktValid;
  assign schedBus.pkt_format_o    = pktEntry.format;
  assign schedBus.pkt_subformat_o = pktEntry.subformat;
  assign schedBus.pkt_thaddr_o    = pktEntry.thaddr;
  assign schedBus.pkt_cause_mux_o = pktEntry.cause_mux;
  assign schedBus.pkt_tval_mux_o  = pktEntry.tval_mux;
  assign schedBus.pkt_sideband_o  = pktSideband;

  always_comb begin
    resyncCnt_d = resyncCnt_q;
    if (resync_rst_i) begin
      resyncCnt_d = '0;
    end else if (resync_cnt_en_i && (resyncCnt_q != RESYNC_W'(MAX_RESYNC))) begin
      resyncCnt_d = resyncCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) resyncCnt_q <= '0;
    else         resyncCnt_q <= resyncCnt_d;
  end

  assign max_resync_o = (resyncCnt_q == RESYNC_W'(MAX_RESYNC));

`ifdef TRDB_PACKETS_LOST_EN
  logic lost_q, lostPulse_q, dropReq;

  assign dropReq   = schedBus.req_valid_i && !acceptPush;
  // After a drop the next accepted request is replaced so the decoder resynchronises.
  assign pushEntry = lost_q ? SUPPORT_ENTRY : reqEntry;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q      <= 1'b0;
      lostPulse_q <= 1'b0;
    end else begin
      lostPulse_q <= dropReq;
      if (dropReq)         lost_q <= 1'b1;
      else if (acceptPush) lost_q <= 1'b0;
    end
  end

  assign packets_lost_o = lostPulse_q;
`else
  assign pushEntry      = reqEntry;
  assign packets_lost_o = 1'b0;
`endif

endmodule

// File: doc/trdb_packet_scheduler.md
Name: trdb_packet_scheduler

Overview:
Sits between the packet-format selector and the packet emitter in the trace encoder. It buffers one-cycle packet requests, which have no backpressure, in a small first-word-fall-through (FWFT) queue and hands them to the emitter over a valid/ready handshake. It injects a format-3/subformat-3 support packet when the halted or reset sideband asserts. It also owns the resync timer that drives the selector's max-resync input.

Parameters:
DEPTH, 4, queue entries; power of 2, at least 2.
MAX_RESYNC, 16, number of counted cycles before max_resync_o asserts.
RESYNC_W, 8, resync counter width; must satisfy MAX_RESYNC < 2^RESYNC_W.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  packet request from the format selector (single-cycle)
req_format_i  in  trdb_format_e  requested packet format
req_subformat_i  in  trdb_f_sync_subformat_e  requested sync subformat
req_thaddr_i  in  1  thaddr payload bit
req_cause_mux_i  in  1  cause select (0 = last cycle, 1 = this cycle)
req_tval_mux_i  in  1  tval select (0 = last cycle, 1 = this cycle)
halted_i  in  1  hart halted sideband (level)
reset_i  in  1  hart reset sideband (level)
resync_rst_i  in  1  clears the resync counter
resync_cnt_en_i  in  1  counts one resync cycle
pkt_valid_o  out  1  packet available to the emitter
pkt_ready_i  in  1  emitter accepts the packet
pkt_format_o  out  trdb_format_e  packet format
pkt_subformat_o  out  trdb_f_sync_subformat_e  sync subformat
pkt_thaddr_o  out  1  thaddr payload bit
pkt_cause_mux_o  out  1  cause select
pkt_tval_mux_o  out  1  tval select
pkt_sideband_o  out  1  only meaningful on injected support packets: 1 = reset, 0 = halted
max_resync_o  out  1  resync threshold reached
packets_lost_o  out  1  a request was dropped (see Optional Feature)

Behaviour:
- Reset: queue empty; FSM in IDLE; counters 0; every output 0. pkt_format_o and pkt_subformat_o reset to encoding 0.
- Queue: FWFT, entry = {format, subformat, thaddr, cause_mux, tval_mux}.
  - Push when req_valid_i is high. Pop on pkt_valid_o && pkt_ready_i while the queue is the output source.
  - Push-to-pkt_valid_o latency is 1 cycle. Outputs come straight from the head entry, registered.
  - Full with a simultaneous pop: the push is accepted.
  - Full without a pop: the request is dropped and the queue is unchanged.
  - Empty with a simultaneous push: no pop; the entry appears next cycle.
  - Pointers are log2(DEPTH) bits with a separate occupancy count (0..DEPTH) and wrap naturally.
- Handshake: while pkt_valid_o is high and pkt_ready_i is low, all pkt_* outputs are held stable.
- Sideband edge: sb = halted_i | reset_i, registered as sb_q. sb_rise = sb & ~sb_q.
- FSM states:
  - IDLE: output comes from the queue. On sb_rise, latch sb_kind = reset_i (reset wins if both are high) and go to DRAIN.
  - DRAIN: output comes from the queue; pushes are still accepted. Go to SUPPORT when the queue is empty and req_valid_i is low in the same cycle.
  - SUPPORT: pkt_valid_o = 1, format = F_SYNC, subformat = SF_SUPPORT, thaddr = cause_mux = tval_mux = 0, pkt_sideband_o = sb_kind.
    - Queue pops are blocked; pushes still enqueue.
    - On handshake go to HOLD.
  - HOLD: output comes from the queue. Go to IDLE when sb = 0. Further sideband edges are ignored while in HOLD.
- pkt_sideband_o is 0 whenever the output source is the queue.
- Resync counter:
  - resync_rst_i takes priority and clears the counter to 0.
  - Otherwise resync_cnt_en_i increments it, saturating at MAX_RESYNC.
  - max_resync_o = (cnt == MAX_RESYNC), combinational from the counter register.
  - Reset and increment in the same cycle gives 0.
- Asynchronous reset mid-packet aborts it: the queue is flushed and the FSM returns to IDLE. No partial state survives.

Optional Feature:
TRDB_PACKETS_LOST_EN
- Defined:
  - A drop pulses packets_lost_o for 1 cycle.
  - A sticky lost flag is set on any drop.
  - On the next push accepted after a drop, the scheduler enqueues F_SYNC/SF_SUPPORT instead of the request, then clears the flag. The original request is discarded.
- Undefined: drops are silent, packets_lost_o is tied 0, and no flag logic is built.

Decomposition:
- trdb_pkg owns trdb_format_e and trdb_f_sync_subformat_e (already present). Add trdb_sched_state_e (IDLE, DRAIN, SUPPORT, HOLD) and the trdb_sched_entry_t packed struct.
- The queue is a natural sub-module: trdb_sched_fifo (parameter DEPTH, entry type, push/pop/full/empty/occupancy).

Test Plan:
- Reset, then 3 back-to-back pushes (F_DIFF_DELTA, F_ADDR_ONLY, F_SYNC/SF_TRAP) with pkt_ready_i=1: pkt_valid_o rises 1 cycle after the first push, and the 3 packets appear in order on consecutive cycles.
- DEPTH=4, pkt_ready_i=0, 5 pushes: 4 are held and the 5th is dropped. packets_lost_o pulses when TRDB_PACKETS_LOST_EN is defined and stays 0 when it is not. With pkt_ready_i=0 held, outputs stay stable.
- 2 entries queued, halted_i rises: both drain, then a F_SYNC/SF_SUPPORT packet appears with pkt_sideband_o=0. A push made during SUPPORT appears after the support handshake.
- halted_i and reset_i rise in the same cycle: the support packet has pkt_sideband_o=1. A second rise before both drop does not produce a second support packet.
- MAX_RESYNC=16: 16 enable cycles assert max_resync_o, which stays high on a 17th. resync_rst_i together with enable clears it in 1 cycle.
- rst_ni asserted during SUPPORT with pkt_ready_i=0: all outputs are 0 immediately. After release, pkt_valid_o stays 0 until a new push.
